// File: rtl/bounce_gen.sv
// Contact-bounce emulator: turns a clean level change on `in` into a burst of
// LFSR-timed glitches on `out` that always ends at the synchronized input level.
`timescale 1ns/1ps
module bounce_gen #(
  parameter int          C_BOUNCES  = 4,
  parameter int          C_MIN_CYC  = 20,
  parameter int          C_RND_BITS = 6,
  parameter logic [15:0] C_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
);

  localparam int          CW       = $clog2(C_MIN_CYC + 2**C_RND_BITS);
  localparam int          LAST     = 2*C_BOUNCES + 1;
  localparam int          EW       = $clog2(LAST + 1);
  localparam logic [15:0] SEED0    = (C_SEED == 16'h0000) ? 16'h0001 : C_SEED;
  localparam logic [15:0] RND_MASK = 16'((32'd1 << C_RND_BITS) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_SETTLE} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, in_s_q;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic            target_q, target_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   edge_q, edge_d;
  logic [15:0]     lfsr_adv;
  logic [CW-1:0]   seg_w;
  logic [CW-1:0]   min_w;

  // Galois step; the segment width is taken from the post-step value.
  assign lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign min_w    = CW'(C_MIN_CYC);
  assign seg_w    = min_w + CW'(lfsr_adv & RND_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      in_s_q   <= 1'b0;
      state_q  <= S_IDLE;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      target_q <= 1'b0;
      lfsr_q   <= SEED0;
      cnt_q    <= '0;
      edge_q   <= '0;
    end else begin
      sync1_q  <= in;
      in_s_q   <= sync1_q;
      state_q  <= state_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      target_q <= target_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    busy_d   = busy_q;
    target_d = target_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    case (state_q)
      S_IDLE: begin
        if (in_s_q != out_q) begin
          target_d = in_s_q;
          out_d    = ~out_q;
          busy_d   = 1'b1;
          lfsr_d   = lfsr_adv;
          edge_d   = EW'(1);
          if (C_BOUNCES == 0) begin
            cnt_d   = min_w;
            state_d = S_SETTLE;
          end else begin
            cnt_d   = seg_w;
            state_d = S_BOUNCE;
          end
        end
      end
      S_BOUNCE: begin
        // Counter loaded with W toggles after exactly W cycles.
        if (cnt_q == CW'(1)) begin
          lfsr_d = lfsr_adv;
          edge_d = edge_q + EW'(1);
          if (edge_q == EW'(LAST - 1)) begin
            out_d   = target_q;
            cnt_d   = min_w;
            state_d = S_SETTLE;
          end else begin
            out_d = ~out_q;
            cnt_d = seg_w;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Randomized bench for bounce_gen: a burst planner pushes expected edge times
// into queues, and a negedge monitor pops them as out/busy actually change.
`timescale 1ns/1ps
module tb_bounce_gen;

  localparam int          B    = 2;
  localparam int          MIN  = 20;
  localparam int          R    = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          WMAX = MIN + (1 << R) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, dbusy;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bounce_gen #(
    .C_BOUNCES (B),
    .C_MIN_CYC (MIN),
    .C_RND_BITS(R),
    .C_SEED    (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .busy(dbusy)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];       // {level, cycle} of each expected out edge
  logic [31:0] exp_busy_q[$];  // {level, cycle} of each expected busy change
  int          errors = 0;
  int          checks = 0;

  logic        m_out;
  logic [15:0] m_lfsr;
  int          m_free;         // cycle on which the model's busy drops

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_out  = 1'b0;
    m_lfsr = SEED;
    m_free = -10;
  endtask

  // Input changed to lvl on cycle t: schedule the burst it causes, if any.
  task automatic plan(input int t, input logic lvl);
    int   s;
    int   e;
    logic o;
    if (lvl == m_out) return;
    s = (t + 3 > m_free + 1) ? t + 3 : m_free + 1;
    o = m_out;
    e = s;
    for (int k = 1; k <= 2*B + 1; k++) begin
      o      = ~o;
      m_lfsr = lfsr_step(m_lfsr);
      exp_q.push_back({o, 31'(e)});
      if (k == 1) exp_busy_q.push_back({1'b1, 31'(s)});
      if (k < 2*B + 1) e = e + MIN + int'(m_lfsr & 16'((1 << R) - 1));
    end
    m_out  = o;
    m_free = e + MIN;
    exp_busy_q.push_back({1'b0, 31'(m_free)});
  endtask

  // ---------------- monitor ----------------
  logic prev_out  = 1'b0;
  logic prev_busy = 1'b0;
  int   last_edge = -1;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      prev_out  = 1'b0;
      prev_busy = 1'b0;
      last_edge = -1;
    end else begin
      if (dout !== prev_out) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected_edge", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          chk("out_edge_cycle", cyc, int'(e[30:0]));
          chk("out_edge_level", int'(dout), int'(e[31]));
        end
        if (prev_busy && last_edge >= 0) begin
          checks++;
          if (cyc - last_edge < MIN || cyc - last_edge > WMAX) begin
            errors++;
            $display("FAIL seg_width: got %0d expected %0d..%0d", cyc - last_edge, MIN, WMAX);
          end
        end
        last_edge = cyc;
      end
      if (dbusy !== prev_busy) begin
        if (exp_busy_q.size() == 0) begin
          chk("busy_unexpected_edge", cyc, -1);
        end else begin
          e = exp_busy_q.pop_front();
          chk("busy_edge_cycle", cyc, int'(e[30:0]));
          chk("busy_edge_level", int'(dbusy), int'(e[31]));
        end
      end
      prev_out  = dout;
      prev_busy = dbusy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int extra);
    while (cyc <= m_free + extra) @(negedge clk);
  endtask

  task automatic flip_in();
    din = ~din;
    plan(cyc, din);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    wait_cycles(2);
    chk("reset_out", int'(dout), 0);
    chk("reset_busy", int'(dbusy), 0);
    #1 rst = 1'b0;
    wait_cycles(5);
    chk("idle_out", int'(dout), 0);

    // Random transitions, some with a reversal mid-burst.
    for (int i = 0; i < 40; i++) begin
      wait_idle($urandom_range(0, 12));
      flip_in();
      if ($urandom_range(0, 3) == 0) begin
        wait_cycles($urandom_range(5, 60));
        flip_in();
      end
    end
    wait_idle(3);
    chk("final_out_matches_in", int'(dout), int'(din));

    // Reset in the middle of a rising burst while in stays high.
    if (din) begin
      flip_in();
      wait_idle(2);
    end
    flip_in();
    wait_cycles(30);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out", int'(dout), 0);
    chk("async_reset_busy", int'(dbusy), 0);
    exp_q.delete();
    exp_busy_q.delete();
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    plan(cyc, din);

    for (int i = 0; i < 8; i++) begin
      wait_idle($urandom_range(0, 6));
      flip_in();
    end
    wait_idle(5);
    chk("drain_out_queue", exp_q.size(), 0);
    chk("drain_busy_queue", exp_busy_q.size(), 0);
    chk("end_out_matches_in", int'(dout), int'(din));
    chk("end_busy_low", int'(dbusy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable contact-bounce emulator, the source-side counterpart of `debounce`: it turns a clean level change on `in` into a burst of pseudo-random glitches that ends at the new level. It sits between a clean stimulus (DIP switch, test FSM, or bench) and a `debounce` instance. This lets the traffic-light pushbutton path be exercised on-board and in simulation with repeatable, seed-controlled bounce patterns.

## Interface
- `C_BOUNCES`, 4: number of extra glitch pairs per transition; 0 means a single clean edge.
- `C_MIN_CYC`, 20: minimum length of each output segment, in clk cycles; must be ≥ 1.
- `C_RND_BITS`, 6: width of the random extension added to each segment, 0..15; 0 gives fixed segments.
- `C_SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `in`, in, 1: clean level; may be asynchronous to `clk`.
- `out`, out, 1: bouncy level, registered.
- `busy`, out, 1: high while a bounce burst or its settle time is in progress.

## Operation
- `in` passes through a 2-FF synchronizer to give `in_s`.
- FSM states: IDLE, BOUNCE, SETTLE.
- **IDLE:**
  - `out` holds its value and `busy` is 0.
  - When `in_s != out`: latch `target = in_s`, toggle `out`, set `busy = 1`, load the segment counter with W, set the edge counter to 1, and go to BOUNCE.
- **BOUNCE:**
  - The segment counter counts down. At expiry `out` toggles, the edge counter increments, and W reloads.
  - After edge number 2·C_BOUNCES+1, `out` equals `target`. The counter then loads C_MIN_CYC and the FSM goes to SETTLE.
  - With C_BOUNCES = 0, the FSM goes from IDLE straight to SETTLE.
- **SETTLE:**
  - The counter counts down C_MIN_CYC cycles, then the FSM returns to IDLE and `busy` drops.
- **Segment width:**
  - W = C_MIN_CYC + (lfsr & (2^C_RND_BITS − 1)), zero-extended.
  - The segment counter is $clog2(C_MIN_CYC + 2^C_RND_BITS) bits wide.
- **LFSR:**
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances exactly once per output edge, including the first, so W for segment k uses the post-edge value.
- **Changes on `in` during BOUNCE/SETTLE** are ignored. On return to IDLE, `in_s` is compared against `out` again, so `out` always converges to the current `in`.
- **Reset** (async, any state): `out = 0`, `busy = 0`, FSM = IDLE, lfsr = C_SEED (or 1 if C_SEED is 0), counters = 0, synchronizer = 0.
  - An in-progress burst is abandoned.
  - After release, if `in` = 1, a fresh burst starts through the normal IDLE path.

## Timing
- Latency from `in` change to the first `out` edge: 3 rising edges (2 synchronizer + 1 FSM register).
- `out` holds exactly W cycles between consecutive edges, so every glitch pulse is ≥ C_MIN_CYC cycles.
- `busy` rises on the same edge as the first `out` toggle.
- `busy` falls exactly C_MIN_CYC cycles after the final toggle.
- Worst-case busy length: (2·C_BOUNCES)·(C_MIN_CYC + 2^C_RND_BITS − 1) + C_MIN_CYC cycles.
- For meaningful `debounce` tests, choose parameters so that this is below the debounce interval.
- Both outputs come straight from flops, with no combinational path from `in`.

## Test plan
1. **Deterministic burst.** C_RND_BITS = 0, C_MIN_CYC = 20, C_BOUNCES = 2; `in` 0→1 sampled at cycle 0.
   - `out` toggles at cycles 3, 23, 43, 63, 83 (final level 1).
   - `busy` is high for cycles 3..102 and low at 103.
2. **Falling burst.** Same parameters, `in` 1→0 after idle.
   - Mirrored sequence of 5 edges ending at 0.
   - Exactly one 20-cycle settle.
3. **Input flip mid-burst.** `in` returns to 0 at cycle 50 in scenario 1.
   - The burst still completes at 1 (cycle 83), and `busy` falls at 103.
   - At cycle 104 a new burst starts toward 0 and ends with `out` = 0.
4. **Random mode.** C_RND_BITS = 6, C_SEED = 16'hACE1; 100 random transitions spaced by at least the worst-case busy length.
   - Every segment is within [20, 83] cycles and each burst has exactly 2·C_BOUNCES+1 edges.
   - Final `out` equals `in`.
   - Two runs with the same seed are cycle-identical.
5. **Reset and clean mode.**
   - `rst` asserted mid-burst (between clk edges): `out` = 0 and `busy` = 0 immediately.
   - With `in` = 1 held, a burst restarts 3 cycles after release.
   - With C_BOUNCES = 0: a single edge, then 20 busy cycles.
6. **Loopback with `debounce`** (C_CLK_FRQ = 100 MHz, C_INTERVAL = 0.010 ms, C_MIN_CYC = 20, C_RND_BITS = 4).
   - Each `in` transition produces exactly one `debounce.out` transition, after `bounce_gen` finishes its settle.
